// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller
// Central stall/flush sequencer for the 5-stage pipeline. It merges the
// load-use hazard, the EX branch resolution, the mul/div handshake and the
// data-memory handshake into per-stage write enables, a bubble select and
// flush strobes. Multi-cycle mul/div and memory waits are tracked by a small
// FSM and bounded by timeouts, so a hung unit cannot freeze the core forever.
//
// Optional build macro: PIPE_PERF_COUNTERS_EN
//   defined   -> saturating stall / flush / mul-div performance counters
//   undefined -> counter outputs are tied to zero
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_RUN    | normal flow; hazards and branches resolved combinationally
// ST_MD_WAIT| front end and EX frozen until md_done or MD timeout
// ST_MEM_WAIT| whole pipe frozen until dmem_ready or MEM timeout

module pipeline_stall_controller #(
   parameter int MD_TIMEOUT  = 64,
   parameter int MEM_TIMEOUT = 256,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_use,
   input  logic             branch_taken,
   input  logic             md_start,
   input  logic             md_done,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             PCwrite,
   output logic             IF_IDwrite,
   output logic             ID_EXwrite,
   output logic             EX_MEMwrite,
   output logic             MEM_WBwrite,
   output logic             control_sel,
   output logic             IF_IDflush,
   output logic             ID_EXflush,
   output logic             EX_MEMbubble,
   output logic             timeout_err,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count,
   output logic [CNT_W-1:0] md_cycles
);

   localparam int MAX_TIMEOUT = (MD_TIMEOUT > MEM_TIMEOUT) ? MD_TIMEOUT : MEM_TIMEOUT;
   localparam int WAIT_W      = $clog2(MAX_TIMEOUT) + 1;

   localparam logic [WAIT_W-1:0] MD_LIMIT  = WAIT_W'(MD_TIMEOUT);
   localparam logic [WAIT_W-1:0] MEM_LIMIT = WAIT_W'(MEM_TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MD_WAIT  = 2'd1,
      ST_MEM_WAIT = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [WAIT_W-1:0] wait_cnt;
   logic [WAIT_W-1:0] wait_cnt_nxt;
   logic              timeout_hit;

   logic              mem_stall;
   logic              md_stall;

   assign mem_stall = dmem_req & ~dmem_ready;
   assign md_stall  = md_start & ~md_done;

   // State register, wait counter and sticky timeout flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_RUN;
         wait_cnt    <= '0;
         timeout_err <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         if (timeout_hit) begin
            timeout_err <= 1'b1;
         end
      end
   end

   // Next-state decode and zero-latency stall/flush outputs.
   always_comb begin
      PCwrite      = 1'b1;
      IF_IDwrite   = 1'b1;
      ID_EXwrite   = 1'b1;
      EX_MEMwrite  = 1'b1;
      MEM_WBwrite  = 1'b1;
      control_sel  = 1'b1;
      IF_IDflush   = 1'b0;
      ID_EXflush   = 1'b0;
      EX_MEMbubble = 1'b0;
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      timeout_hit  = 1'b0;

      unique case (state)
         ST_RUN: begin
            wait_cnt_nxt = '0;
            if (mem_stall) begin
               PCwrite      = 1'b0;
               IF_IDwrite   = 1'b0;
               ID_EXwrite   = 1'b0;
               EX_MEMwrite  = 1'b0;
               MEM_WBwrite  = 1'b0;
               state_nxt    = ST_MEM_WAIT;
               wait_cnt_nxt = WAIT_ONE;
            end else if (md_stall) begin
               PCwrite      = 1'b0;
               IF_IDwrite   = 1'b0;
               ID_EXwrite   = 1'b0;
               EX_MEMbubble = 1'b1;
               state_nxt    = ST_MD_WAIT;
               wait_cnt_nxt = WAIT_ONE;
            end else if (branch_taken) begin
               IF_IDflush = 1'b1;
               ID_EXflush = 1'b1;
            end else if (load_use) begin
               PCwrite     = 1'b0;
               IF_IDwrite  = 1'b0;
               control_sel = 1'b0;
            end
         end

         ST_MEM_WAIT: begin
            // Branch and load-use are deliberately ignored here; the frozen
            // EX instruction presents them again once the pipe is released.
            if (dmem_ready) begin
               state_nxt    = ST_RUN;
               wait_cnt_nxt = '0;
            end else if (wait_cnt == MEM_LIMIT) begin
               timeout_hit  = 1'b1;
               state_nxt    = ST_RUN;
               wait_cnt_nxt = '0;
            end else begin
               PCwrite      = 1'b0;
               IF_IDwrite   = 1'b0;
               ID_EXwrite   = 1'b0;
               EX_MEMwrite  = 1'b0;
               MEM_WBwrite  = 1'b0;
               wait_cnt_nxt = wait_cnt + WAIT_ONE;
            end
         end

         ST_MD_WAIT: begin
            if (md_done) begin
               state_nxt    = ST_RUN;
               wait_cnt_nxt = '0;
            end else if (wait_cnt == MD_LIMIT) begin
               timeout_hit  = 1'b1;
               state_nxt    = ST_RUN;
               wait_cnt_nxt = '0;
            end else begin
               PCwrite      = 1'b0;
               IF_IDwrite   = 1'b0;
               ID_EXwrite   = 1'b0;
               EX_MEMbubble = 1'b1;
               // An older load/store still waiting in MEM must also hold the
               // back end; the FSM stays in MD_WAIT since mul/div owns the wait.
               if (mem_stall) begin
                  EX_MEMwrite = 1'b0;
                  MEM_WBwrite = 1'b0;
               end
               wait_cnt_nxt = wait_cnt + WAIT_ONE;
            end
         end

         default: begin
            state_nxt    = ST_RUN;
            wait_cnt_nxt = '0;
         end
      endcase

      // Reset flushes every stage and injects NOP controls regardless of
      // state, so an in-flight wait is abandoned immediately.
      if (reset) begin
         PCwrite      = 1'b1;
         IF_IDwrite   = 1'b1;
         ID_EXwrite   = 1'b1;
         EX_MEMwrite  = 1'b1;
         MEM_WBwrite  = 1'b1;
         control_sel  = 1'b0;
         IF_IDflush   = 1'b1;
         ID_EXflush   = 1'b1;
         EX_MEMbubble = 1'b1;
         state_nxt    = ST_RUN;
         wait_cnt_nxt = '0;
         timeout_hit  = 1'b0;
      end
   end

`ifdef PIPE_PERF_COUNTERS_EN

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] flush_cnt_q;
   logic [CNT_W-1:0] md_cnt_q;

   // Saturating performance counters; they stick at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         md_cnt_q    <= '0;
      end else begin
         if (!PCwrite && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + CNT_ONE;
         end
         if (IF_IDflush && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_q <= flush_cnt_q + CNT_ONE;
         end
         if ((state == ST_MD_WAIT) && (md_cnt_q != CNT_MAX)) begin
            md_cnt_q <= md_cnt_q + CNT_ONE;
         end
      end
   end

   assign stall_cycles = stall_cnt_q;
   assign flush_count  = flush_cnt_q;
   assign md_cycles    = md_cnt_q;

`else

   assign stall_cycles = '0;
   assign flush_count  = '0;
   assign md_cycles    = '0;

`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller. A default-parameter instance
// covers the priority table and the multi-cycle sequences; a second instance
// with short timeouts covers forced release and the sticky error flag.

module tb_pipeline_stall_controller;

`ifdef PIPE_PERF_COUNTERS_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   // Packed output order: PC IF_ID ID_EX EX_MEM MEM_WB control_sel IF_IDflush ID_EXflush EX_MEMbubble
   localparam logic [8:0] O_NORM   = 9'b11111_1_000;
   localparam logic [8:0] O_RESET  = 9'b11111_0_111;
   localparam logic [8:0] O_MEMST  = 9'b00000_1_000;
   localparam logic [8:0] O_MDST   = 9'b00011_1_001;
   localparam logic [8:0] O_MDMEM  = 9'b00000_1_001;
   localparam logic [8:0] O_BRANCH = 9'b11111_1_110;
   localparam logic [8:0] O_LDUSE  = 9'b00111_0_000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, t_reset;
   logic load_use, branch_taken, md_start, md_done, dmem_req, dmem_ready;

   logic PCwrite, IF_IDwrite, ID_EXwrite, EX_MEMwrite, MEM_WBwrite;
   logic control_sel, IF_IDflush, ID_EXflush, EX_MEMbubble, timeout_err;
   logic [31:0] stall_cycles, flush_count, md_cycles;

   logic t_PCwrite, t_IF_IDwrite, t_ID_EXwrite, t_EX_MEMwrite, t_MEM_WBwrite;
   logic t_control_sel, t_IF_IDflush, t_ID_EXflush, t_EX_MEMbubble, t_timeout_err;
   logic [31:0] t_stall_cycles, t_flush_count, t_md_cycles;

   pipeline_stall_controller dut (
      .clk(clk), .reset(reset),
      .load_use(load_use), .branch_taken(branch_taken),
      .md_start(md_start), .md_done(md_done),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .PCwrite(PCwrite), .IF_IDwrite(IF_IDwrite), .ID_EXwrite(ID_EXwrite),
      .EX_MEMwrite(EX_MEMwrite), .MEM_WBwrite(MEM_WBwrite),
      .control_sel(control_sel), .IF_IDflush(IF_IDflush), .ID_EXflush(ID_EXflush),
      .EX_MEMbubble(EX_MEMbubble), .timeout_err(timeout_err),
      .stall_cycles(stall_cycles), .flush_count(flush_count), .md_cycles(md_cycles)
   );

   pipeline_stall_controller #(.MD_TIMEOUT(4), .MEM_TIMEOUT(8), .CNT_W(32)) dut_to (
      .clk(clk), .reset(t_reset),
      .load_use(load_use), .branch_taken(branch_taken),
      .md_start(md_start), .md_done(md_done),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready),
      .PCwrite(t_PCwrite), .IF_IDwrite(t_IF_IDwrite), .ID_EXwrite(t_ID_EXwrite),
      .EX_MEMwrite(t_EX_MEMwrite), .MEM_WBwrite(t_MEM_WBwrite),
      .control_sel(t_control_sel), .IF_IDflush(t_IF_IDflush), .ID_EXflush(t_ID_EXflush),
      .EX_MEMbubble(t_EX_MEMbubble), .timeout_err(t_timeout_err),
      .stall_cycles(t_stall_cycles), .flush_count(t_flush_count), .md_cycles(t_md_cycles)
   );

   logic [8:0] o, t_o;
   assign o   = {PCwrite, IF_IDwrite, ID_EXwrite, EX_MEMwrite, MEM_WBwrite,
                 control_sel, IF_IDflush, ID_EXflush, EX_MEMbubble};
   assign t_o = {t_PCwrite, t_IF_IDwrite, t_ID_EXwrite, t_EX_MEMwrite, t_MEM_WBwrite,
                 t_control_sel, t_IF_IDflush, t_ID_EXflush, t_EX_MEMbubble};

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       lu, br, ms, md, dr, dy;
      logic [8:0] exp;
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic lu, input logic br, input logic ms,
                         input logic md, input logic dr, input logic dy);
      load_use     = lu;
      branch_taken = br;
      md_start     = ms;
      md_done      = md;
      dmem_req     = dr;
      dmem_ready   = dy;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      set_in(0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
   endtask

   function automatic logic [31:0] perf(input int n);
      return PERF ? 32'(n) : 32'd0;
   endfunction

   initial begin
      reset   = 1'b1;
      t_reset = 1'b1;
      set_in(0, 0, 0, 0, 0, 0);

      //            lu br ms md dr dy  expected
      vecs[0]  = '{0, 0, 0, 0, 0, 0, O_NORM};
      vecs[1]  = '{1, 0, 0, 0, 0, 0, O_LDUSE};
      vecs[2]  = '{0, 1, 0, 0, 0, 0, O_BRANCH};
      vecs[3]  = '{1, 1, 0, 0, 0, 0, O_BRANCH};
      vecs[4]  = '{0, 0, 1, 1, 0, 0, O_NORM};
      vecs[5]  = '{1, 0, 1, 1, 0, 0, O_LDUSE};
      vecs[6]  = '{0, 0, 0, 0, 1, 1, O_NORM};
      vecs[7]  = '{0, 1, 0, 0, 1, 1, O_BRANCH};
      vecs[8]  = '{1, 1, 1, 0, 0, 0, O_MDST};   // enter MD_WAIT
      vecs[9]  = '{0, 0, 1, 0, 1, 0, O_MDMEM};  // MD_WAIT with memory also stalled
      vecs[10] = '{1, 1, 1, 1, 0, 0, O_NORM};   // md_done releases, branch ignored
      vecs[11] = '{0, 0, 1, 0, 1, 0, O_MEMST};  // memory beats mul/div, enter MEM_WAIT
      vecs[12] = '{1, 0, 0, 0, 1, 1, O_NORM};   // dmem_ready releases, load_use ignored
      vecs[13] = '{0, 1, 1, 1, 1, 1, O_BRANCH};
      vecs[14] = '{0, 0, 0, 0, 0, 0, O_NORM};

      next_cycle();

      // Reset held two cycles, then idle RUN.
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("reset_outputs", o, O_RESET);
         next_cycle();
      end
      reset = 1'b0;
      @(negedge clk);
      chk("post_reset_outputs", o, O_NORM);
      chk("post_reset_stall_cycles", stall_cycles, 32'd0);
      chk("post_reset_flush_count", flush_count, 32'd0);
      chk("post_reset_md_cycles", md_cycles, 32'd0);
      chk("post_reset_timeout_err", timeout_err, 32'd0);
      next_cycle();

      // Priority table.
      do_reset();
      for (int i = 0; i < 15; i++) begin
         set_in(vecs[i].lu, vecs[i].br, vecs[i].ms, vecs[i].md, vecs[i].dr, vecs[i].dy);
         @(negedge clk);
         chk($sformatf("vec%0d", i), o, vecs[i].exp);
         next_cycle();
      end

      // Single load-use bubble.
      do_reset();
      set_in(1, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("load_use_stall", o, O_LDUSE);
      next_cycle();
      set_in(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("load_use_after", o, O_NORM);
      chk("load_use_stall_cycles", stall_cycles, perf(1));
      next_cycle();

      // Mul/div with md_done five cycles after md_start.
      do_reset();
      set_in(0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("md_wait_c%0d", i), o, O_MDST);
         next_cycle();
      end
      md_done = 1'b1;
      @(negedge clk);
      chk("md_done_release", o, O_NORM);
      next_cycle();
      set_in(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("md_after", o, O_NORM);
      chk("md_md_cycles", md_cycles, perf(5));
      chk("md_stall_cycles", stall_cycles, perf(5));
      chk("md_no_timeout", timeout_err, 32'd0);
      next_cycle();

      // Memory wait with a pending branch; flush only after release.
      do_reset();
      set_in(0, 1, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("mem_br_wait_c%0d", i), o, O_MEMST);
         next_cycle();
      end
      dmem_ready = 1'b1;
      @(negedge clk);
      chk("mem_br_release", o, O_NORM);
      next_cycle();
      set_in(0, 1, 0, 0, 0, 0);
      @(negedge clk);
      chk("mem_br_flush", o, O_BRANCH);
      next_cycle();
      set_in(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("mem_br_after", o, O_NORM);
      chk("mem_br_flush_count", flush_count, perf(1));
      chk("mem_br_stall_cycles", stall_cycles, perf(3));
      next_cycle();

      // Reset in the second cycle of MEM_WAIT aborts the wait.
      do_reset();
      set_in(0, 0, 0, 0, 1, 0);
      @(negedge clk);
      chk("mem_rst_entry", o, O_MEMST);
      next_cycle();
      @(negedge clk);
      chk("mem_rst_wait1", o, O_MEMST);
      next_cycle();
      reset = 1'b1;
      @(negedge clk);
      chk("mem_rst_during", o, O_RESET);
      next_cycle();
      reset = 1'b0;
      set_in(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("mem_rst_after", o, O_NORM);
      next_cycle();
      @(negedge clk);
      chk("mem_rst_after2", o, O_NORM);
      chk("mem_rst_stall_cycles", stall_cycles, 32'd0);
      next_cycle();

      // Short-timeout instance: mul/div never completes.
      reset = 1'b1;
      set_in(0, 0, 0, 0, 0, 0);
      next_cycle();
      t_reset = 1'b0;
      set_in(0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("md_to_stall_c%0d", i), t_o, O_MDST);
         next_cycle();
      end
      @(negedge clk);
      chk("md_to_release", t_o, O_NORM);
      chk("md_to_err_not_yet", t_timeout_err, 32'd0);
      next_cycle();
      set_in(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("md_to_err_set", t_timeout_err, 32'd1);
      chk("md_to_after", t_o, O_NORM);
      chk("md_to_md_cycles", t_md_cycles, perf(4));
      chk("md_to_stall_cycles", t_stall_cycles, perf(4));
      next_cycle();

      // Later traffic leaves the sticky flag set.
      set_in(1, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("to_traffic_lu", t_o, O_LDUSE);
      next_cycle();
      set_in(0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk($sformatf("to_traffic_mem_c%0d", i), t_o, O_MEMST);
         next_cycle();
      end
      dmem_ready = 1'b1;
      @(negedge clk);
      chk("to_traffic_mem_release", t_o, O_NORM);
      next_cycle();
      set_in(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("to_err_sticky", t_timeout_err, 32'd1);
      next_cycle();
      t_reset = 1'b1;
      next_cycle();
      t_reset = 1'b0;
      @(negedge clk);
      chk("to_err_cleared_by_reset", t_timeout_err, 32'd0);
      next_cycle();

      // Memory never ready: eight stall cycles, release at count 8.
      set_in(0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk($sformatf("mem_to_stall_c%0d", i), t_o, O_MEMST);
         next_cycle();
      end
      @(negedge clk);
      chk("mem_to_release", t_o, O_NORM);
      next_cycle();
      set_in(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("mem_to_err_set", t_timeout_err, 32'd1);
      next_cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Merges four inputs into per-stage write enables, bubble select and flush strobes:
  - the load-use hazard flag from hazard detection,
  - branch-taken from EX,
  - the multi-cycle mul/div unit handshake,
  - the data-memory ready handshake.
- Holds a small FSM so that multi-cycle mul/div and memory waits are sequenced and bounded by timeouts.

Parameters:
MD_TIMEOUT, 64, max cycles spent in MD_WAIT before forced release
MEM_TIMEOUT, 256, max cycles spent in MEM_WAIT before forced release
CNT_W, 32, width of performance counters

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
load_use  input  1  load-use hazard from hazard detection (load in EX, dependent in ID)
branch_taken  input  1  taken branch/jump resolved in EX
md_start  input  1  mul/div instruction present in EX this cycle
md_done  input  1  mul/div result valid this cycle
dmem_req  input  1  MEM stage issuing a data-memory access
dmem_ready  input  1  data memory completes access this cycle
PCwrite  output  1  PC update enable
IF_IDwrite  output  1  IF/ID register enable
ID_EXwrite  output  1  ID/EX register enable
EX_MEMwrite  output  1  EX/MEM register enable
MEM_WBwrite  output  1  MEM/WB register enable
control_sel  output  1  1 = pass decoded controls into ID/EX, 0 = insert bubble
IF_IDflush  output  1  clear IF/ID
ID_EXflush  output  1  clear ID/EX
EX_MEMbubble  output  1  write NOP controls into EX/MEM
timeout_err  output  1  sticky: MD or MEM timeout occurred
stall_cycles  output  CNT_W  perf counter
flush_count  output  CNT_W  perf counter
md_cycles  output  CNT_W  perf counter

Behaviour:
- Outputs are combinational from state plus inputs; zero-cycle latency, as hazard logic requires.
- State register and counters are updated on the rising edge of clk.
- Normal values: all *write = 1, control_sel = 1, flushes and bubble = 0.
- Reset asserted:
  - state <= RUN, wait counter <= 0, timeout_err <= 0, perf counters <= 0.
  - Outputs forced to: all *write = 1, IF_IDflush = 1, ID_EXflush = 1, EX_MEMbubble = 1, control_sel = 0.
  - Reset mid-MD_WAIT or mid-MEM_WAIT aborts the wait immediately.
- States: RUN, MD_WAIT, MEM_WAIT.
- Priority in RUN, highest first:
  1. dmem_req && !dmem_ready:
     - all five *write = 0.
     - next state MEM_WAIT, counter <= 1.
  2. md_start && !md_done:
     - PCwrite = IF_IDwrite = ID_EXwrite = 0; EX_MEMbubble = 1.
     - next state MD_WAIT, counter <= 1.
  3. branch_taken: IF_IDflush = 1, ID_EXflush = 1, writes normal.
  4. load_use: PCwrite = 0, IF_IDwrite = 0, control_sel = 0 (single bubble).
  5. Otherwise normal outputs.
- md_start && md_done in the same RUN cycle: no stall.
- MEM_WAIT:
  - Outputs as priority 1 while !dmem_ready; counter increments.
  - dmem_ready = 1: normal outputs this cycle, next RUN.
  - Counter == MEM_TIMEOUT: timeout_err <= 1, normal outputs, next RUN.
- MD_WAIT:
  - Outputs as priority 2 while !md_done.
  - md_done = 1: normal outputs, next RUN.
  - Timeout as for MEM, using MD_TIMEOUT.
  - dmem_req && !dmem_ready in MD_WAIT: additionally EX_MEMwrite = 0 and MEM_WBwrite = 0. State stays MD_WAIT.
- branch_taken and load_use are ignored outside RUN; the frozen EX instruction re-presents them on release.
- Wait counter: clog2(max(MD_TIMEOUT, MEM_TIMEOUT)) + 1 bits; cleared on every entry to RUN.
- timeout_err is cleared only by reset.

Optional Feature:
- Macro PIPE_PERF_COUNTERS_EN.
- Defined:
  - stall_cycles += 1 on any cycle with PCwrite = 0.
  - flush_count += 1 on each cycle with IF_IDflush = 1 outside reset.
  - md_cycles += 1 per cycle in MD_WAIT.
  - All counters saturate at 2^CNT_W-1 (no wrap).
- Undefined: counters absent, all three outputs tied to 0.

Test Plan:
- Reset held 2 cycles, then RUN idle: during reset flushes = 1 and control_sel = 0. After release all *write = 1, control_sel = 1, counters 0.
- load_use = 1 for one cycle in RUN: same cycle PCwrite = 0, IF_IDwrite = 0, control_sel = 0. Next cycle, with load_use = 0, all normal; stall_cycles = 1.
- md_start = 1, md_done arriving 5 cycles later:
  - 5 cycles of PCwrite = IF_IDwrite = ID_EXwrite = 0 and EX_MEMbubble = 1 (entry cycle + 4 MD_WAIT cycles), normal on the md_done cycle.
  - md_cycles = 5, stall_cycles = 5.
- dmem_req = 1, dmem_ready = 0 for 3 cycles while branch_taken = 1: all writes 0, no flush. Branch flush is applied only after release, while branch_taken is still asserted. flush_count increments once.
- MD_TIMEOUT = 4, md_done never asserted: release after the counter reaches 4 and timeout_err = 1. timeout_err stays 1 through later traffic until reset.
- Reset asserted in cycle 2 of MEM_WAIT: next cycle state is RUN, all writes 1, no residual stall.
